// File: rtl/trdb_packet_emitter_buf.sv
// trdb_packet_emitter_buf
//   Assembles E-trace payloads (SYNC / ADDR_ONLY / DIFF_DELTA) from a request,
//   queues them in a FIFO_DEPTH-entry FIFO and hands them to the encapsulator
//   over a valid/ready handshake. Owns the last-sent-address register used for
//   delta addressing and raises the branch-map flush pulse.
//
//   Optional build macro: TRDB_ADDR_COMPRESS_EN
//     When defined, START / ADDR_ONLY / DELTA-with-address packets are shortened
//     to the fewest bytes that still let the decoder sign-extend the top bit.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   valid_i / ready_o     request handshake (ready_o = FIFO not full)
//   format_i..branch_map_i request fields
//   packet_valid_o / packet_ready_i   FIFO head handshake
//   packet_payload_o      head payload, LSB-first, zero above its length
//   payload_length_o      head length in bytes
//   branch_map_flush_o    one-cycle pulse after DIFF_DELTA / START / TRAP accept
//   overflow_o            sticky: request arrived while full
//   unsupported_o         one-cycle pulse after an accepted format-0 request
//   fifo_count_o          FIFO occupancy
module trdb_packet_emitter_buf #(
  parameter int XLEN           = 32,
  parameter int PRIV_LEN       = 2,
  parameter int CAUSE_LEN      = 5,
  parameter int BRANCH_MAP_LEN = 31,
  parameter int FIFO_DEPTH     = 4,
  parameter int PAYLOAD_LEN    = 2*XLEN + PRIV_LEN + CAUSE_LEN + 8,
  parameter int P_LEN          = $clog2(PAYLOAD_LEN/8 + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  input  logic [1:0]                         format_i,
  input  logic [1:0]                         subformat_i,
  input  logic                               branch_i,
  input  logic [PRIV_LEN-1:0]                priv_i,
  input  logic [XLEN-1:0]                    iaddr_i,
  input  logic [CAUSE_LEN-1:0]               cause_i,
  input  logic                               interrupt_i,
  input  logic                               thaddr_i,
  input  logic [XLEN-1:0]                    tval_i,
  input  logic [1:0]                         qual_status_i,
  input  logic                               updiscon_i,
  input  logic [4:0]                         branches_i,
  input  logic [BRANCH_MAP_LEN-1:0]          branch_map_i,
  output logic                               packet_valid_o,
  input  logic                               packet_ready_i,
  output logic [PAYLOAD_LEN-1:0]             packet_payload_o,
  output logic [P_LEN-1:0]                   payload_length_o,
  output logic                               branch_map_flush_o,
  output logic                               overflow_o,
  output logic                               unsupported_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] FMT_OPT   = 2'd0;
  localparam logic [1:0] FMT_DELTA = 2'd1;
  localparam logic [1:0] FMT_ADDR  = 2'd2;
  localparam logic [1:0] FMT_SYNC  = 2'd3;

  localparam logic [1:0] SF_START   = 2'd0;
  localparam logic [1:0] SF_TRAP    = 2'd1;
  localparam logic [1:0] SF_CONTEXT = 2'd2;

  // Field bit counts per packet kind
  localparam int FB_START   = 5 + PRIV_LEN + XLEN;
  localparam int FB_TRAP    = 7 + PRIV_LEN + CAUSE_LEN + 2*XLEN;
  localparam int FB_CONTEXT = 4 + PRIV_LEN;
  localparam int FB_SUPPORT = 11;
  localparam int FB_ADDR    = 5 + XLEN;
  localparam int FB_DADDR   = 10 + BRANCH_MAP_LEN + XLEN;
  localparam int FB_DNOADDR = 7 + BRANCH_MAP_LEN;

  localparam logic [P_LEN-1:0] LEN_START   = P_LEN'((FB_START   + 7) / 8);
  localparam logic [P_LEN-1:0] LEN_TRAP    = P_LEN'((FB_TRAP    + 7) / 8);
  localparam logic [P_LEN-1:0] LEN_CONTEXT = P_LEN'((FB_CONTEXT + 7) / 8);
  localparam logic [P_LEN-1:0] LEN_SUPPORT = P_LEN'((FB_SUPPORT + 7) / 8);
  localparam logic [P_LEN-1:0] LEN_ADDR    = P_LEN'((FB_ADDR    + 7) / 8);
  localparam logic [P_LEN-1:0] LEN_DADDR   = P_LEN'((FB_DADDR   + 7) / 8);
  localparam logic [P_LEN-1:0] LEN_DNOADDR = P_LEN'((FB_DNOADDR + 7) / 8);

`ifdef TRDB_ADDR_COMPRESS_EN
  // Smallest byte count L such that bits [fb-1 : 8L-1] all match the top
  // field bit, so the decoder can sign-extend the truncated upper bytes.
  function automatic logic [P_LEN-1:0] compress_len(input logic [PAYLOAD_LEN-1:0] p,
                                                    input int fb);
    logic [P_LEN-1:0] len;
    logic             found;
    logic             ok;
    len   = P_LEN'((fb + 7) / 8);
    found = 1'b0;
    for (int l = 1; l <= PAYLOAD_LEN/8 + 1; l++) begin
      ok = 1'b1;
      for (int i = 0; i < PAYLOAD_LEN; i++) begin
        if (i >= 8*l - 1 && i < fb && p[i] != p[fb-1]) ok = 1'b0;
      end
      if (ok && !found) begin
        len   = P_LEN'(l);
        found = 1'b1;
      end
    end
    return len;
  endfunction
`endif

  logic [CNT_W-1:0]        count_q;
  logic [PTR_W-1:0]        wr_ptr_q;
  logic [PTR_W-1:0]        rd_ptr_q;
  logic [XLEN-1:0]         latest_addr_q;
  logic                    overflow_q;
  logic                    flush_p1;
  logic                    unsupported_p1;

  logic [PAYLOAD_LEN-1:0]  mem_payload [FIFO_DEPTH];
  logic [P_LEN-1:0]        mem_len     [FIFO_DEPTH];

  logic                    accept;
  logic                    push;
  logic                    pop;
  logic [XLEN-1:0]         diff;
  logic                    addr_notify;
  logic                    addr_upd;
  logic                    diff_notify;
  logic                    diff_upd;
  logic [PAYLOAD_LEN-1:0]  payload_d;
  logic [P_LEN-1:0]        len_d;
  logic                    addr_load;
  logic                    flush_req;

  assign ready_o        = (count_q != CNT_W'(FIFO_DEPTH));
  assign accept         = valid_i & ready_o;
  assign push           = accept & (format_i != FMT_OPT);
  assign packet_valid_o = (count_q != '0);
  assign pop            = packet_valid_o & packet_ready_i;

  // Delta address wraps modulo 2^XLEN; notify mirrors the top address bit so
  // the upper bits of the packet form a sign-extension run.
  assign diff        = iaddr_i - latest_addr_q;
  assign addr_notify = iaddr_i[XLEN-1];
  assign addr_upd    = addr_notify ^ updiscon_i;
  assign diff_notify = diff[XLEN-1];
  assign diff_upd    = diff_notify ^ updiscon_i;

  // ---- Stage 0: payload assembly from request and latest_addr_q ----
  always_comb begin
    payload_d = '0;
    len_d     = '0;
    addr_load = 1'b0;
    flush_req = 1'b0;
    case (format_i)
      FMT_SYNC: begin
        case (subformat_i)
          SF_START: begin
            payload_d = PAYLOAD_LEN'({iaddr_i, priv_i, branch_i, subformat_i, format_i});
`ifdef TRDB_ADDR_COMPRESS_EN
            len_d = compress_len(payload_d, FB_START);
`else
            len_d = LEN_START;
`endif
            addr_load = 1'b1;
            flush_req = 1'b1;
          end
          SF_TRAP: begin
            payload_d = PAYLOAD_LEN'({tval_i, iaddr_i, thaddr_i, interrupt_i, cause_i,
                                      priv_i, branch_i, subformat_i, format_i});
            len_d     = LEN_TRAP;
            addr_load = 1'b1;
            flush_req = 1'b1;
          end
          SF_CONTEXT: begin
            payload_d = PAYLOAD_LEN'({priv_i, subformat_i, format_i});
            len_d     = LEN_CONTEXT;
          end
          default: begin
            // ioptions=3'b001, qual_status, encoder_mode=0, ienable=1
            payload_d = PAYLOAD_LEN'({3'b001, qual_status_i, 1'b0, 1'b1, subformat_i, format_i});
            len_d     = LEN_SUPPORT;
          end
        endcase
      end
      FMT_ADDR: begin
        payload_d = PAYLOAD_LEN'({addr_upd, addr_upd, addr_notify, iaddr_i, format_i});
`ifdef TRDB_ADDR_COMPRESS_EN
        len_d = compress_len(payload_d, FB_ADDR);
`else
        len_d = LEN_ADDR;
`endif
        addr_load = 1'b1;
      end
      FMT_DELTA: begin
        flush_req = 1'b1;
        if (branches_i != 5'd31) begin
          payload_d = PAYLOAD_LEN'({diff_upd, diff_upd, diff_notify, diff,
                                    branch_map_i, branches_i, format_i});
`ifdef TRDB_ADDR_COMPRESS_EN
          len_d = compress_len(payload_d, FB_DADDR);
`else
          len_d = LEN_DADDR;
`endif
          addr_load = 1'b1;
        end else begin
          // Full branch map: no address field is carried
          payload_d = PAYLOAD_LEN'({branch_map_i, branches_i, format_i});
          len_d     = LEN_DNOADDR;
        end
      end
      default: ;
    endcase
`ifdef TRDB_ADDR_COMPRESS_EN
    for (int i = 0; i < PAYLOAD_LEN; i++) begin
      if (i >= 8*int'(len_d)) payload_d[i] = 1'b0;
    end
`endif
  end

  // ---- Stage 1: FIFO storage (data, not reset) ----
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_payload[wr_ptr_q] <= payload_d;
      mem_len[wr_ptr_q]     <= len_d;
    end
  end

  // ---- Stage 1: FIFO control, address tracking, status pulses ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      latest_addr_q  <= '0;
      overflow_q     <= 1'b0;
      flush_p1       <= 1'b0;
      unsupported_p1 <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (accept && addr_load) latest_addr_q <= iaddr_i;
      if (valid_i && !ready_o) overflow_q <= 1'b1;
      flush_p1       <= accept & flush_req;
      unsupported_p1 <= accept & (format_i == FMT_OPT);
    end
  end

  assign packet_payload_o   = packet_valid_o ? mem_payload[rd_ptr_q] : '0;
  assign payload_length_o   = packet_valid_o ? mem_len[rd_ptr_q] : '0;
  assign branch_map_flush_o = flush_p1;
  assign overflow_o         = overflow_q;
  assign unsupported_o      = unsupported_p1;
  assign fifo_count_o       = count_q;

endmodule
